// File: rtl/icache_refill_ctrl_pkg.sv
// Shared constants for the instruction-cache refill path: line geometry,
// address field boundaries and the refill FSM state encoding.
package icache_refill_ctrl_pkg;

    localparam int LINE_BITS   = 128;
    localparam int OFFSET_BITS = 4;
    localparam int INDEX_LSB   = 4;
    localparam int TAG_LSB     = 6;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_FILL = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        FILL = ST_FILL,
        DONE = ST_DONE
    } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_timer.sv
// Refill wait timer: cleared while requesting, counts response-wait cycles,
// flags the last allowed cycle before a re-request.
module icache_refill_ctrl_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss service: one line-aligned memory read per miss,
// single-cycle cache fill, timeout re-request and a saturating refill count.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BITS_LINE  = LINE_BITS,
    parameter int INDEX_BITS = 2,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      miss,
    input  logic [ADDR_WIDTH-1:0]     miss_addr,
    output logic                      stall,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [BITS_LINE-1:0]      mem_rdata,
    output logic                      cache_we,
    output logic [INDEX_BITS-1:0]     cache_index,
    output logic [ADDR_WIDTH-TAG_LSB-1:0] cache_tag,
    output logic [BITS_LINE-1:0]      cache_line,
    output logic [CNT_WIDTH-1:0]      refill_cnt,
    output logic                      timeout_err
);

    refill_state_e state, nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BITS_LINE-1:0]  line_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  terr_q;
    logic                  tc;
    logic                  unused_offset;

    // Byte offset within the line never reaches memory or the cache.
    assign unused_offset = ^miss_addr[OFFSET_BITS-1:0];

    icache_refill_ctrl_timer #(.LIMIT(TIMEOUT)) u_refill_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == REQ),
        .en    (state == WAIT),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (miss) nxt = REQ;
            REQ:     if (mem_gnt) nxt = WAIT;
            WAIT: begin
                // A response on the terminal cycle still completes the refill.
                if (mem_rvalid)  nxt = FILL;
                else if (tc)     nxt = REQ;
            end
            FILL:    nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            line_q <= '0;
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            if (state == IDLE && miss)
                addr_q <= {miss_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            if (state == WAIT && mem_rvalid)
                line_q <= mem_rdata;
            if (state == WAIT && !mem_rvalid && tc)
                terr_q <= 1'b1;
            if (state == FILL && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // stall is gated by reset so a held miss cannot freeze fetch during reset.
    assign stall       = rst_n && ((state == IDLE) ? miss :
                                   (state == REQ || state == WAIT || state == FILL));
    assign mem_req     = (state == REQ);
    assign mem_addr    = addr_q;
    assign cache_we    = (state == FILL);
    assign cache_index = addr_q[INDEX_LSB +: INDEX_BITS];
    assign cache_tag   = addr_q[ADDR_WIDTH-1:TAG_LSB];
    assign cache_line  = line_q;
    assign refill_cnt  = cnt_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized refill bench against a transaction-level model of the miss
// service: expected address masking, saturating count and sticky timeout.
module tb_icache_refill_ctrl;

    localparam int AW  = 32;
    localparam int LB  = 128;
    localparam int IB  = 2;
    localparam int TMO = 8;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           miss;
    logic [AW-1:0]  miss_addr;
    logic           stall;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [LB-1:0]  mem_rdata;
    logic           cache_we;
    logic [IB-1:0]  cache_index;
    logic [AW-7:0]  cache_tag;
    logic [LB-1:0]  cache_line;
    logic [CW-1:0]  refill_cnt;
    logic           timeout_err;

    icache_refill_ctrl #(
        .ADDR_WIDTH (AW),
        .BITS_LINE  (LB),
        .INDEX_BITS (IB),
        .TIMEOUT    (TMO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .miss        (miss),
        .miss_addr   (miss_addr),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .cache_we    (cache_we),
        .cache_index (cache_index),
        .cache_tag   (cache_tag),
        .cache_line  (cache_line),
        .refill_cnt  (refill_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: completed refills, sticky timeout, last filled line.
    int            n_refill  = 0;
    bit            exp_terr  = 1'b0;
    logic [LB-1:0] last_line = '0;

    function automatic logic [127:0] exp_cnt();
        return 128'((n_refill > CNT_MAX) ? CNT_MAX : n_refill);
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Idle cycles with spurious handshakes; nothing may move.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            miss       = 1'b0;
            mem_gnt    = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("idle_req",   128'(mem_req),  128'(0));
            chk("idle_we",    128'(cache_we), 128'(0));
            chk("idle_stall", 128'(stall),    128'(0));
            chk("idle_cnt",   128'(refill_cnt), exp_cnt());
            chk("idle_line",  128'(cache_line), 128'(last_line));
            @(negedge clk);
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // One complete miss service; starts and ends on a negedge with the DUT idle.
    task automatic refill(input logic [AW-1:0] a, input int gdly, input bit tmo,
                          input int rdly, input logic [LB-1:0] d,
                          input bit b2b, input logic [AW-1:0] na);
        logic [AW-1:0] la;
        la = a & ~32'hF;
        miss = 1'b1;
        miss_addr = a;
        #1;
        chk("stall_miss", 128'(stall),   128'(1));
        chk("req_idle",   128'(mem_req), 128'(0));
        @(negedge clk);
        miss = 1'b0;
        miss_addr = $urandom;
        for (int i = 0; i < gdly; i++) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
            chk("req_hold",  128'(mem_req),  128'(1));
            chk("req_addr",  128'(mem_addr), 128'(la));
            chk("req_we",    128'(cache_we), 128'(0));
            chk("req_stall", 128'(stall),    128'(1));
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        chk("req_hold",  128'(mem_req),  128'(1));
        chk("req_addr",  128'(mem_addr), 128'(la));
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (tmo) begin
            for (int i = 0; i < TMO; i++) begin
                chk("wait_req",   128'(mem_req), 128'(0));
                chk("wait_stall", 128'(stall),   128'(1));
                @(negedge clk);
            end
            exp_terr = 1'b1;
            chk("retry_req",  128'(mem_req),     128'(1));
            chk("retry_addr", 128'(mem_addr),    128'(la));
            chk("retry_terr", 128'(timeout_err), 128'(1));
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
        end
        for (int i = 0; i < rdly; i++) begin
            chk("wait_req", 128'(mem_req),  128'(0));
            chk("wait_we",  128'(cache_we), 128'(0));
            @(negedge clk);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
        chk("fill_we",    128'(cache_we),    128'(1));
        chk("fill_req",   128'(mem_req),     128'(0));
        chk("fill_index", 128'(cache_index), 128'(la[5:4]));
        chk("fill_tag",   128'(cache_tag),   128'(la[31:6]));
        chk("fill_line",  128'(cache_line),  128'(d));
        chk("fill_stall", 128'(stall),       128'(1));
        n_refill++;
        last_line = d;
        @(negedge clk);
        miss       = b2b ? 1'b1 : 1'($urandom_range(0, 1));
        miss_addr  = na;
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        #1;
        chk("done_we",    128'(cache_we),    128'(0));
        chk("done_stall", 128'(stall),       128'(0));
        chk("done_cnt",   128'(refill_cnt),  exp_cnt());
        chk("done_terr",  128'(timeout_err), 128'(exp_terr));
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a, na;
        bit b2b;
        rst_n = 1'b0;
        miss = 1'b1;
        miss_addr = 32'h0000_0154;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req",   128'(mem_req),     128'(0));
        chk("rst_we",    128'(cache_we),    128'(0));
        chk("rst_stall", 128'(stall),       128'(0));
        chk("rst_cnt",   128'(refill_cnt),  128'(0));
        chk("rst_terr",  128'(timeout_err), 128'(0));
        chk("rst_addr",  128'(mem_addr),    128'(0));
        rst_n = 1'b1;
        miss = 1'b0;
        idle_cycles(2);

        // Basic refill, delayed grant, timeout with rvalid on terminal cycle.
        refill(32'h0000_0154, 0, 1'b0, 4, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 32'h0);
        idle_cycles(2);
        refill(32'h0000_0030, 7, 1'b0, 2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 32'h0);
        idle_cycles(1);
        refill(32'h0000_1238, 1, 1'b1, TMO - 1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 32'h0000_0040);
        refill(32'h0000_0040, 0, 1'b0, 0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 32'h0);
        idle_cycles(1);

        // Random refills past the counter saturation point.
        a = $urandom;
        for (int k = 0; k < 16; k++) begin
            na  = $urandom;
            b2b = 1'($urandom_range(0, 1));
            refill(a, $urandom_range(0, 5), ($urandom_range(0, 4) == 0),
                   $urandom_range(0, TMO - 1), {$urandom, $urandom, $urandom, $urandom}, b2b, na);
            if (!b2b) idle_cycles($urandom_range(1, 3));
            a = na;
        end
        if (miss) idle_cycles(0);
        miss = 1'b0;
        chk("sat_cnt", 128'(refill_cnt), 128'(CNT_MAX));

        // Reset while waiting for the memory response.
        miss = 1'b1;
        miss_addr = 32'h0000_0AB0;
        @(negedge clk);
        miss = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2;
        miss = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   128'(mem_req),     128'(0));
        chk("mid_rst_stall", 128'(stall),       128'(0));
        chk("mid_rst_cnt",   128'(refill_cnt),  128'(0));
        chk("mid_rst_terr",  128'(timeout_err), 128'(0));
        chk("mid_rst_addr",  128'(mem_addr),    128'(0));
        n_refill  = 0;
        exp_terr  = 1'b0;
        last_line = '0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        #1;
        chk("mid_rst_we", 128'(cache_we), 128'(0));
        @(negedge clk);
        mem_rvalid = 1'b0;
        miss = 1'b0;
        rst_n = 1'b1;
        idle_cycles(3);

        for (int k = 0; k < 3; k++) begin
            refill($urandom, $urandom_range(0, 3), 1'b0, $urandom_range(0, TMO - 1),
                   {$urandom, $urandom, $urandom, $urandom}, 1'b0, 32'h0);
            idle_cycles(1);
        end
        chk("post_rst_cnt", 128'(refill_cnt), 128'(3));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
